// File: rtl/cmos_writer_pkg.sv
// Shared definitions for the CMOS frame writer.
//   state_e      : frame-writer FSM states
//   burst_len_w  : width of a burst word count able to hold BURST_LEN itself
package cmos_writer_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ACK  = 3'd1,
        S_WAIT = 3'd2,
        S_REQ  = 3'd3,
        S_DATA = 3'd4
    } state_e;

    function automatic int burst_len_w(input int burst_len);
        return $clog2(burst_len) + 1;
    endfunction

endpackage

// File: rtl/cmos_wr_fifo.sv
// Capture FIFO for the CMOS frame writer: synchronous, show-ahead (head word
// visible on dout_o without a pop), with occupancy level and synchronous clear.
// Ports:
//   pclk, rst       clock, asynchronous active-high reset
//   clr_i           synchronous flush (wins over push/pop)
//   push_i, din_i   write one word; ignored when full
//   pop_i           discard head word; ignored when empty
//   dout_o          head word
//   level_o         words stored (0..DEPTH)
//   full_o, empty_o occupancy flags
module cmos_wr_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 256
) (
    input  logic                   pclk,
    input  logic                   rst,
    input  logic                   clr_i,
    input  logic                   push_i,
    input  logic [W-1:0]           din_i,
    input  logic                   pop_i,
    output logic [W-1:0]           dout_o,
    output logic [$clog2(DEPTH):0] level_o,
    output logic                   full_o,
    output logic                   empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_LVL = DEPTH[AW:0];
    localparam logic [AW:0]   ONE_LVL  = 1;
    localparam logic [AW-1:0] ONE_PTR  = 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   level_q;
    logic          do_push, do_pop;

    assign full_o  = (level_q == FULL_LVL);
    assign empty_o = (level_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign dout_o  = mem_q[rd_ptr_q];
    assign level_o = level_q;

    always_ff @(posedge pclk) begin
        if (do_push && !clr_i) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + ONE_PTR;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + ONE_PTR;
            if (do_push && !do_pop)      level_q <= level_q + ONE_LVL;
            else if (!do_push && do_pop) level_q <= level_q - ONE_LVL;
        end
    end

endmodule

// File: rtl/cmos_frame_writer.sv
// CMOS frame writer: acknowledges a frame-start request, captures one frame of
// CMOS pixels into a local FIFO and drains it to the memory controller as
// bursts of at most BURST_LEN words into bank (write_addr_index << BANK_SHIFT).
// Optional feature macro: CMOS_BYTE_PACK_EN -- cmos_data is 8 bits and two
// qualified bytes (first byte high) form one 16-bit word.
// Ports:
//   pclk, rst                     clock, asynchronous active-high reset
//   write_req/write_addr_index    frame-start request (level) and target bank
//   write_req_ack                 one-cycle acknowledge
//   cmos_href/cmos_de/cmos_data   pixel stream
//   wr_burst_*                    memory controller burst write port
//   frame_done                    pulse when the last frame word is written
//   overflow                      sticky pixel-drop flag, cleared on acknowledge
//   fsm_state_o                   current FSM state (debug)
//
// Burst handshake: wr_burst_req with a stable wr_burst_addr/wr_burst_len is held
// until the controller returns wr_burst_ack for one cycle; afterwards each
// wr_burst_data_req cycle consumes the word on wr_burst_data (already valid in
// that cycle), and wr_burst_finish closes the burst.
module cmos_frame_writer
    import cmos_writer_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 24,
    parameter int BANK_SHIFT  = 19,
    parameter int FRAME_WORDS = 307200,
    parameter int BURST_LEN   = 64,
    parameter int FIFO_DEPTH  = 256
) (
    input  logic                              pclk,
    input  logic                              rst,
    input  logic                              write_req,
    input  logic [1:0]                        write_addr_index,
    output logic                              write_req_ack,
    input  logic                              cmos_href,
    input  logic                              cmos_de,
`ifdef CMOS_BYTE_PACK_EN
    input  logic [7:0]                        cmos_data,
`else
    input  logic [DATA_W-1:0]                 cmos_data,
`endif
    output logic                              wr_burst_req,
    output logic [ADDR_W-1:0]                 wr_burst_addr,
    output logic [burst_len_w(BURST_LEN)-1:0] wr_burst_len,
    input  logic                              wr_burst_ack,
    input  logic                              wr_burst_data_req,
    output logic [DATA_W-1:0]                 wr_burst_data,
    input  logic                              wr_burst_finish,
    output logic                              frame_done,
    output logic                              overflow,
    output state_e                            fsm_state_o
);
    localparam int LW  = burst_len_w(BURST_LEN);
    localparam int CW  = $clog2(FRAME_WORDS + 1);
    localparam int LVW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] FRAME_CNT = CW'(FRAME_WORDS);
    localparam logic [CW-1:0] ONE_CNT   = 1;

    state_e              state_q, state_d;
    logic [1:0]          bank_q, bank_d;
    logic [CW-1:0]       wr_cnt_q, wr_cnt_d;
    logic [CW-1:0]       cap_cnt_q, cap_cnt_d;
    logic                cap_en_q, cap_en_d;
    logic                overflow_q, overflow_d;
    logic [DATA_W-1:0]   last_q, last_d;

    logic                fifo_clr, fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [DATA_W-1:0]   fifo_dout, word;
    logic [LVW-1:0]      fifo_level;
    logic                word_vld, cap_active, busy, done;
    logic [31:0]         rem_words, need_words;
    logic [LW-1:0]       burst_len;

    // Capture stops by itself once a whole frame of pixels has been counted.
    assign cap_active = cap_en_q && (cap_cnt_q != FRAME_CNT);

`ifdef CMOS_BYTE_PACK_EN
    logic [7:0] hi_q, hi_d;
    logic       hi_vld_q, hi_vld_d;

    // A half word left over when the line ends is thrown away.
    always_comb begin
        hi_d     = hi_q;
        hi_vld_d = hi_vld_q;
        word_vld = 1'b0;
        word     = DATA_W'({hi_q, cmos_data});
        if (state_q == S_ACK || !cmos_href) begin
            hi_vld_d = 1'b0;
        end else if (cap_active && cmos_de) begin
            if (hi_vld_q) begin
                word_vld = 1'b1;
                hi_vld_d = 1'b0;
            end else begin
                hi_d     = cmos_data;
                hi_vld_d = 1'b1;
            end
        end
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            hi_q     <= '0;
            hi_vld_q <= 1'b0;
        end else begin
            hi_q     <= hi_d;
            hi_vld_q <= hi_vld_d;
        end
    end
`else
    assign word_vld = cap_active & cmos_href & cmos_de;
    assign word     = cmos_data;
`endif

    assign fifo_clr  = (state_q == S_ACK);
    assign fifo_push = word_vld & ~fifo_clr;
    assign fifo_pop  = (state_q == S_DATA) & wr_burst_data_req;

    cmos_wr_fifo #(
        .W     (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .pclk    (pclk),
        .rst     (rst),
        .clr_i   (fifo_clr),
        .push_i  (fifo_push),
        .din_i   (word),
        .pop_i   (fifo_pop),
        .dout_o  (fifo_dout),
        .level_o (fifo_level),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Burst size: a full burst, or the frame tail when fewer words remain.
    assign rem_words  = 32'(FRAME_WORDS) - 32'(wr_cnt_q);
    assign need_words = (rem_words < 32'(BURST_LEN)) ? rem_words : 32'(BURST_LEN);
    assign burst_len  = LW'(need_words);
    assign busy       = (state_q == S_REQ) || (state_q == S_DATA);

    always_comb begin
        state_d    = state_q;
        bank_d     = bank_q;
        wr_cnt_d   = wr_cnt_q;
        cap_cnt_d  = cap_cnt_q;
        cap_en_d   = cap_en_q;
        overflow_d = overflow_q;
        last_d     = last_q;
        done       = 1'b0;

        // A dropped pixel still counts toward the frame.
        if (fifo_push) begin
            cap_cnt_d = cap_cnt_q + ONE_CNT;
            if (fifo_full) overflow_d = 1'b1;
        end
        // Remember the last popped word so an empty FIFO still shows it.
        if (fifo_pop && !fifo_empty) last_d = fifo_dout;

        unique case (state_q)
            S_IDLE: if (write_req) state_d = S_ACK;
            S_ACK: begin
                bank_d     = write_addr_index;
                wr_cnt_d   = '0;
                cap_cnt_d  = '0;
                overflow_d = 1'b0;
                cap_en_d   = 1'b1;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                if (write_req) begin
                    state_d = S_ACK;
                end else if (wr_cnt_q != FRAME_CNT && 32'(fifo_level) >= need_words) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: if (wr_burst_ack) state_d = S_DATA;
            S_DATA: begin
                if (wr_burst_finish) begin
                    wr_cnt_d = wr_cnt_q + CW'(burst_len);
                    done     = (wr_cnt_d == FRAME_CNT);
                    // A request seen during the burst is served once it ends.
                    if (write_req)  state_d = S_ACK;
                    else if (done)  state_d = S_IDLE;
                    else            state_d = S_WAIT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            bank_q     <= '0;
            wr_cnt_q   <= '0;
            cap_cnt_q  <= '0;
            cap_en_q   <= 1'b0;
            overflow_q <= 1'b0;
            last_q     <= '0;
        end else begin
            state_q    <= state_d;
            bank_q     <= bank_d;
            wr_cnt_q   <= wr_cnt_d;
            cap_cnt_q  <= cap_cnt_d;
            cap_en_q   <= cap_en_d;
            overflow_q <= overflow_d;
            last_q     <= last_d;
        end
    end

    assign write_req_ack = (state_q == S_ACK);
    assign wr_burst_req  = (state_q == S_REQ);
    assign wr_burst_addr = busy ? ((ADDR_W'(bank_q) << BANK_SHIFT) + ADDR_W'(wr_cnt_q)) : '0;
    assign wr_burst_len  = busy ? burst_len : '0;
    assign wr_burst_data = fifo_empty ? last_q : fifo_dout;
    assign frame_done    = done;
    assign overflow      = overflow_q;
    assign fsm_state_o   = state_q;

endmodule
